io_arbiter: RTL

Shares the single memory I/O bus port between the two I/O requesters: the VGA framebuffer reader (index `VGA_I` = 0) and the PS/2 keyboard writer (index `PS2_I` = 1). It arbitrates round-robin and translates virtual addresses to physical ones: VGA adds `VGA_MEM_OFFSET`, and PS/2 targets the fixed `KEYBOARD_ADD`. It sequences exactly one memory transaction at a time and returns completion to the winner. It sits between the `gc`-parameterised memory and the VGA/PS2 controllers.

---
 rtl/io_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - round-robin VGA/PS2 arbiter for the shared memory I/O port.
// Optional ACCESS watchdog compiled in with `define IO_ARB_TIMEOUT_EN.
package gc;
    localparam int          WORD_SIZE      = 64;
    localparam int          ASCII_SIZE     = 8;
    localparam logic [63:0] VGA_MEM_OFFSET = 64'h81;
    localparam logic [63:0] KEYBOARD_ADD   = 64'h0;
    localparam logic        IO_IN          = 1'b1;
    localparam logic        IO_OUT         = 1'b0;
    localparam logic        VGA_I          = 1'b0;
    localparam logic        PS2_I          = 1'b1;
endpackage

module io_arbiter #(
    parameter int ADDR_W  = gc::WORD_SIZE,
    parameter int DATA_W  = gc::WORD_SIZE,
    parameter int KEY_W   = gc::ASCII_SIZE,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_done,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              ps2_req,
    input  logic [KEY_W-1:0]  ps2_data,
    output logic              ps2_gnt,
    output logic              ps2_done,
    output logic              mem_req,
    output logic              mem_dir,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nx;
    logic   winner, winner_d;
    logic   last, last_d;
    logic   pick_ps2;
    logic   timeout;

    logic              vga_gnt_d, ps2_gnt_d, vga_done_d, ps2_done_d;
    logic              mem_req_d, mem_dir_d, busy_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, vga_rdata_d;

`ifdef IO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_d;

    // an ack on the final cycle takes priority over the abort
    assign timeout = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // on a tie, the requester that did not win last time is served
    assign pick_ps2 = ps2_req && (!vga_req || (last == gc::VGA_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= gc::VGA_I;
            last      <= gc::PS2_I;
            vga_gnt   <= 1'b0;
            ps2_gnt   <= 1'b0;
            vga_done  <= 1'b0;
            ps2_done  <= 1'b0;
            vga_rdata <= '0;
            mem_req   <= 1'b0;
            mem_dir   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            winner    <= winner_d;
            last      <= last_d;
            vga_gnt   <= vga_gnt_d;
            ps2_gnt   <= ps2_gnt_d;
            vga_done  <= vga_done_d;
            ps2_done  <= ps2_done_d;
            vga_rdata <= vga_rdata_d;
            mem_req   <= mem_req_d;
            mem_dir   <= mem_dir_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
`ifdef IO_ARB_TIMEOUT_EN
            cnt       <= cnt_d;
            err       <= err_d;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vga_req || ps2_req) state_nx = ACCESS;
            ACCESS:  if (mem_ack || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        winner_d    = winner;
        last_d      = last;
        vga_gnt_d   = vga_gnt;
        ps2_gnt_d   = ps2_gnt;
        vga_done_d  = 1'b0;
        ps2_done_d  = 1'b0;
        vga_rdata_d = vga_rdata;
        mem_req_d   = mem_req;
        mem_dir_d   = mem_dir;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        busy_d      = (state_nx != IDLE);
`ifdef IO_ARB_TIMEOUT_EN
        cnt_d       = cnt;
        err_d       = err;
`endif
        case (state)
            IDLE: begin
                if (vga_req || ps2_req) begin
                    winner_d  = pick_ps2 ? gc::PS2_I : gc::VGA_I;
                    mem_req_d = 1'b1;
                    if (pick_ps2) begin
                        ps2_gnt_d   = 1'b1;
                        mem_dir_d   = gc::IO_IN;
                        mem_addr_d  = ADDR_W'(gc::KEYBOARD_ADD);
                        mem_wdata_d = DATA_W'(ps2_data);
                    end else begin
                        vga_gnt_d   = 1'b1;
                        mem_dir_d   = gc::IO_OUT;
                        mem_addr_d  = vga_addr + ADDR_W'(gc::VGA_MEM_OFFSET);
                        mem_wdata_d = '0;
                    end
`ifdef IO_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ACCESS: begin
                if (mem_ack || timeout) begin
                    mem_req_d   = 1'b0;
                    vga_gnt_d   = 1'b0;
                    ps2_gnt_d   = 1'b0;
                    mem_dir_d   = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (winner == gc::VGA_I) begin
                        vga_done_d  = 1'b1;
                        vga_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        ps2_done_d  = 1'b1;
                    end
`ifdef IO_ARB_TIMEOUT_EN
                    if (timeout) err_d = 1'b1;
`endif
                end else begin
`ifdef IO_ARB_TIMEOUT_EN
                    cnt_d = cnt + 1'b1;
`endif
                end
            end
            DONE: begin
                last_d = winner;
            end
            default: begin
                last_d = last;
            end
        endcase
    end

endmodule
